add_accumulator: RTL and testbench

- Downstream stage of the 4-bit adder. Consumes the adder's {cout, sum} result as one 5-bit value per accepted transfer.
- Accumulates N_SAMPLES results into an ACC_W-bit register, then presents the total on a valid/ready output handshake.
- Sits between the adder and the display/readout logic.

---
 rtl/add_acc_pkg.sv | 24 ++
 rtl/acc_adder.sv | 34 +++
 rtl/add_accumulator.sv | 131 +++++++++++++
 tb/tb_add_accumulator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_acc_pkg.sv
// -----------------------------------------------------------------------------
// add_acc_pkg
// Shared types and helpers for the adder-result accumulator.
//   state_t       : accumulator FSM states (ACCUM collects samples, DONE holds total)
//   DEF_DATA_W    : width of the upstream adder's sum bus
//   EXT_IN_W      : width of one adder result {cout, sum} before extension
//   count_width() : width needed to hold a sample count of 0..n_samples
// -----------------------------------------------------------------------------
package add_acc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 4;
   localparam int EXT_IN_W   = DEF_DATA_W + 1;

   // Count must reach n_samples itself, hence n_samples+1 distinct values.
   function automatic int count_width(input int n_samples);
      return (n_samples < 1) ? 1 : $clog2(n_samples + 1);
   endfunction

endpackage

// File: rtl/acc_adder.sv
// -----------------------------------------------------------------------------
// acc_adder
// Combinational ACC_W-bit adder for the accumulator datapath.
//   acc      : current running total
//   in_ext   : adder result {cout,sum} zero-extended to ACC_W
//   next_acc : total after adding in_ext (wrapped or saturated)
//   ovf      : the add carried out of ACC_W bits
// Build option ADD_ACCUMULATOR_SATURATE_EN: when defined, an overflowing add
// clamps to all ones; otherwise the total wraps modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module acc_adder
   import add_acc_pkg::*;
#(
   parameter int ACC_W = 6
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] in_ext,
   output logic [ACC_W-1:0] next_acc,
   output logic             ovf
);

   logic [ACC_W:0] full_sum;

   assign full_sum = {1'b0, acc} + {1'b0, in_ext};
   assign ovf      = full_sum[ACC_W];

`ifdef ADD_ACCUMULATOR_SATURATE_EN
   // Once saturated, any further non-zero add overflows again and stays at all ones.
   assign next_acc = ovf ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
   assign next_acc = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/add_accumulator.sv
// -----------------------------------------------------------------------------
// add_accumulator
// Collects N_SAMPLES adder results ({cout,sum}) into an ACC_W-bit total and
// offers the total on a valid/ready handshake.
//   clk, reset          : clock and synchronous active-high reset
//   clear               : synchronous frame abort (below reset in priority)
//   in_valid / in_ready : upstream handshake for {cout, sum}
//   sum, cout           : adder result
//   out_valid/out_ready : downstream handshake for the frame total
//   acc                 : running total (final total while out_valid=1)
//   count               : results accepted in the current frame
//   overflow            : sticky, the total exceeded ACC_W bits this frame
// Build option ADD_ACCUMULATOR_SATURATE_EN selects saturating instead of
// wrapping accumulation (see acc_adder); handshake and counting are unchanged.
// -----------------------------------------------------------------------------
module add_accumulator
   import add_acc_pkg::*;
#(
   parameter  int DATA_W    = EXT_IN_W - 1,
   parameter  int ACC_W     = 6,
   parameter  int N_SAMPLES = 4,
   localparam int CNT_W     = count_width(N_SAMPLES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] sum,
   input  logic              cout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   localparam int IN_W = DATA_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

   // Parameter sanity checks at elaboration time.
   if (ACC_W < IN_W) begin : g_bad_acc_w
      $error("add_accumulator: ACC_W must be at least DATA_W+1");
   end
   if (N_SAMPLES < 1) begin : g_bad_n_samples
      $error("add_accumulator: N_SAMPLES must be at least 1");
   end

   state_t             state_reg, state_next;
   logic [ACC_W-1:0]   acc_next;
   logic [CNT_W-1:0]   count_next;
   logic               overflow_next;
   logic [ACC_W-1:0]   in_ext;
   logic [ACC_W-1:0]   add_result;
   logic               add_ovf;
   logic               accept;

   assign in_ext = ACC_W'({cout, sum});

   acc_adder #(
      .ACC_W (ACC_W)
   ) u_acc_adder (
      .acc      (acc),
      .in_ext   (in_ext),
      .next_acc (add_result),
      .ovf      (add_ovf)
   );

   // State register and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ACCUM;
         acc       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
      end else begin
         state_reg <= state_next;
         acc       <= acc_next;
         count     <= count_next;
         overflow  <= overflow_next;
      end
   end

   // Next-state and handshake outputs. out_valid is purely a function of the
   // registered state; only in_ready looks at an input (clear).
   always_comb begin
      state_next    = state_reg;
      acc_next      = acc;
      count_next    = count;
      overflow_next = overflow;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      accept        = 1'b0;

      case (state_reg)
         ACCUM: begin
            in_ready = !clear;
            accept   = in_valid && !clear;
            if (accept) begin
               acc_next      = add_result;
               count_next    = count + CNT_W'(1);
               overflow_next = overflow | add_ovf;
               if (count == LAST_CNT) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acc_next      = '0;
               count_next    = '0;
               overflow_next = 1'b0;
               state_next    = ACCUM;
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase

      // Frame abort wins over any handshake in either state.
      if (clear) begin
         acc_next      = '0;
         count_next    = '0;
         overflow_next = 1'b0;
         state_next    = ACCUM;
      end
   end

endmodule

// File: tb/tb_add_accumulator.sv
// -----------------------------------------------------------------------------
// tb_add_accumulator
// Directed bench for add_accumulator: a frame-level model (running integer
// total per instance) is checked against two DUTs every cycle, plus literal
// expectations at key points of each scenario. Instance 0 uses N_SAMPLES=4,
// instance 1 uses N_SAMPLES=1; both share the stimulus.
// -----------------------------------------------------------------------------
module tb_add_accumulator;

   localparam int ACC_W = 6;
   localparam int N0    = 4;

   logic       clk;
   logic       reset;
   logic       clear;
   logic       in_valid;
   logic [3:0] sum;
   logic       cout;
   logic       out_ready;

   logic       in_ready0, out_valid0, overflow0;
   logic [5:0] acc0;
   logic [2:0] count0;
   logic       in_ready1, out_valid1, overflow1;
   logic [5:0] acc1;
   logic [0:0] count1;

   int n_checks = 0;
   int n_fail   = 0;

   add_accumulator #(.DATA_W(4), .ACC_W(ACC_W), .N_SAMPLES(N0)) dut0 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready0), .sum(sum), .cout(cout), .out_valid(out_valid0),
      .out_ready(out_ready), .acc(acc0), .count(count0), .overflow(overflow0)
   );

   add_accumulator #(.DATA_W(4), .ACC_W(ACC_W), .N_SAMPLES(1)) dut1 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready1), .sum(sum), .cout(cout), .out_valid(out_valid1),
      .out_ready(out_ready), .acc(acc1), .count(count1), .overflow(overflow1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected register value for a true (unbounded) frame total.
   function automatic int exp_acc(input int total);
`ifdef ADD_ACCUMULATOR_SATURATE_EN
      return (total > (1 << ACC_W) - 1) ? (1 << ACC_W) - 1 : total;
`else
      return total % (1 << ACC_W);
`endif
   endfunction

   // ---------------- frame-level model ----------------
   int m_total[2];
   int m_cnt[2];
   bit m_done[2];
   bit model_on = 1'b0;
   int mn;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         mn = (i == 0) ? N0 : 1;
         if (reset || clear) begin
            m_total[i] = 0;
            m_cnt[i]   = 0;
            m_done[i]  = 1'b0;
         end else if (m_done[i]) begin
            if (out_ready) begin
               $display("txn dut%0d read total=%0d count=%0d", i, exp_acc(m_total[i]), m_cnt[i]);
               m_total[i] = 0;
               m_cnt[i]   = 0;
               m_done[i]  = 1'b0;
            end
         end else if (in_valid) begin
            m_total[i] = m_total[i] + int'({cout, sum});
            m_cnt[i]   = m_cnt[i] + 1;
            $display("txn dut%0d accept value=%0d total=%0d", i, int'({cout, sum}), m_total[i]);
            if (m_cnt[i] == mn) m_done[i] = 1'b1;
         end
      end
      if (reset) model_on = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_on) begin
         check("dut0.acc",       acc0,       exp_acc(m_total[0]));
         check("dut0.count",     count0,     m_cnt[0]);
         check("dut0.overflow",  overflow0,  m_total[0] > (1 << ACC_W) - 1);
         check("dut0.out_valid", out_valid0, m_done[0]);
         check("dut0.in_ready",  in_ready0,  !m_done[0] && !clear);
         check("dut1.acc",       acc1,       exp_acc(m_total[1]));
         check("dut1.count",     count1,     m_cnt[1]);
         check("dut1.overflow",  overflow1,  m_total[1] > (1 << ACC_W) - 1);
         check("dut1.out_valid", out_valid1, m_done[1]);
         check("dut1.in_ready",  in_ready1,  !m_done[1] && !clear);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [4:0] v);
      in_valid    = 1'b1;
      {cout, sum} = v;
      step();
      in_valid    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; sum = '0; cout = 1'b0; out_ready = 1'b1;
      step(); step();
      reset = 1'b0;
      check("rst.acc", acc0, 0);
      check("rst.count", count0, 0);
      check("rst.overflow", overflow0, 0);
      check("rst.out_valid", out_valid0, 0);
      check("rst.in_ready", in_ready0, 1);

      // Basic frame: 15+18+3+5 = 41
      send(5'h0F); send(5'h12); send(5'h03); send(5'h05);
      check("t1.acc", acc0, 41);
      check("t1.count", count0, 4);
      check("t1.overflow", overflow0, 0);
      check("t1.out_valid", out_valid0, 1);
      check("t1.in_ready", in_ready0, 0);
      step();
      check("t1.out_valid_drop", out_valid0, 0);
      check("t1.in_ready_back", in_ready0, 1);

      // Overflow frame: four times 31
      send(5'h1F); check("t2.acc1", acc0, 31);
      send(5'h1F); check("t2.acc2", acc0, 62); check("t2.ovf2", overflow0, 0);
`ifdef ADD_ACCUMULATOR_SATURATE_EN
      send(5'h1F); check("t2.acc3", acc0, 63); check("t2.ovf3", overflow0, 1);
      send(5'h1F); check("t2.acc4", acc0, 63);
`else
      send(5'h1F); check("t2.acc3", acc0, 29); check("t2.ovf3", overflow0, 1);
      send(5'h1F); check("t2.acc4", acc0, 60);
`endif
      check("t2.ovf4", overflow0, 1);
      check("t2.out_valid", out_valid0, 1);
      step();
      check("t2.ovf_cleared", overflow0, 0);

      // Backpressure in DONE with new data waiting upstream
      out_ready = 1'b0;
      send(5'd1); send(5'd2); send(5'd3); send(5'd4);
      in_valid = 1'b1; {cout, sum} = 5'd7;
      repeat (5) begin
         step();
         check("t3.hold_acc", acc0, 10);
         check("t3.hold_count", count0, 4);
         check("t3.hold_valid", out_valid0, 1);
         check("t3.hold_in_ready", in_ready0, 0);
      end
      out_ready = 1'b1;
      step();
      check("t3.hs_valid", out_valid0, 0);
      check("t3.hs_acc", acc0, 0);
      check("t3.hs_in_ready", in_ready0, 1);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      check("t3.new_acc", acc0, 7);
      check("t3.new_count", count0, 1);
      send(5'd0); send(5'd0); send(5'd0);
      check("t3.frame2_acc", acc0, 7);
      check("t3.frame2_valid", out_valid0, 1);
      out_ready = 1'b1;
      step();

      // Clear mid-frame, with a sample offered in the same cycle
      send(5'h10); send(5'h11);
      check("t4.acc", acc0, 33);
      check("t4.count", count0, 2);
      clear = 1'b1; in_valid = 1'b1; {cout, sum} = 5'd5;
      #1;
      check("t4.clear_in_ready", in_ready0, 0);
      step();
      clear = 1'b0; in_valid = 1'b0;
      check("t4.clr_acc", acc0, 0);
      check("t4.clr_count", count0, 0);
      send(5'd1); send(5'd1); send(5'd1); send(5'd1);
      check("t4.fresh_acc", acc0, 4);
      check("t4.fresh_valid", out_valid0, 1);
      step();

      // Reset while in DONE with out_ready asserted
      out_ready = 1'b0;
      send(5'd2); send(5'd2); send(5'd2); send(5'd2);
      check("t5.done_acc", acc0, 8);
      out_ready = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0; out_ready = 1'b0;
      check("t5.acc", acc0, 0);
      check("t5.count", count0, 0);
      check("t5.out_valid", out_valid0, 0);
      check("t5.in_ready", in_ready0, 1);

      // Single-sample frames on the N_SAMPLES=1 instance
      send(5'h10);
      check("t6.valid", out_valid1, 1);
      check("t6.acc", acc1, 16);
      check("t6.count", count1, 1);
      check("t6.in_ready", in_ready1, 0);
      out_ready = 1'b1;
      step();
      check("t6.released", out_valid1, 0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
